// File: rtl/mul_issue_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : mul_issue_sched_pkg                                           |
// | Purpose  : Types and constants shared by the multiplier issue scheduler, |
// |            its result FIFO and the pipelined multiplier itself.          |
// | Contents : MUL_FUNC enum, MUL_TAG / MUL_RESULT structs, MUL_STAGES,      |
// |            mul_sign_fix() helper.                                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package mul_issue_sched_pkg;

  localparam int MUL_XLEN   = 32;
  // Multiplier latency; the multiplier instance reads this same constant.
  localparam int MUL_STAGES = 8;
  localparam int PRF_LEN    = 6;
  localparam int ROB_LEN    = 5;

  typedef enum logic [1:0] {
    MUL_FUNC_MUL    = 2'd0,
    MUL_FUNC_MULH   = 2'd1,
    MUL_FUNC_MULHSU = 2'd2,
    MUL_FUNC_MULHU  = 2'd3
  } MUL_FUNC;

  typedef struct packed {
    logic [PRF_LEN-1:0]  prf_idx;
    logic [ROB_LEN-1:0]  rob_idx;
    logic [MUL_XLEN-1:0] pc;
    MUL_FUNC             func;
    logic                a_sign;
    logic                b_sign;
  } MUL_TAG;

  typedef struct packed {
    logic [MUL_XLEN-1:0] value;
    logic [PRF_LEN-1:0]  prf_idx;
    logic [ROB_LEN-1:0]  rob_idx;
    logic [MUL_XLEN-1:0] pc;
  } MUL_RESULT;

  // The multiplier works on operand magnitudes; the sign of the true
  // product is restored here by a full-width negate before the half select.
  function automatic logic [MUL_XLEN-1:0] mul_sign_fix(
    input MUL_FUNC               func,
    input logic                  a_sign,
    input logic                  b_sign,
    input logic [2*MUL_XLEN-1:0] product
  );
    logic                  w_neg;
    logic [2*MUL_XLEN-1:0] w_full;
    case (func)
      MUL_FUNC_MUL,
      MUL_FUNC_MULH:   w_neg = a_sign ^ b_sign;
      MUL_FUNC_MULHSU: w_neg = a_sign;
      default:         w_neg = 1'b0;
    endcase
    w_full = w_neg ? (-product) : product;
    return (func == MUL_FUNC_MUL) ? w_full[MUL_XLEN-1:0]
                                  : w_full[2*MUL_XLEN-1:MUL_XLEN];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_issue_sched_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mul_result_fifo                                               |
// | Purpose  : DEPTH-entry circular FIFO holding completed multiply results  |
// |            until the CDB accepts them.                                   |
// | Ports    : clock, reset_n (async, active low), clear (sync empty),       |
// |            push/push_data, pop, head_data, count, empty                  |
// | Notes    : caller never pushes into a full FIFO unless it also pops in   |
// |            the same cycle, and never pops an empty one.                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mul_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == c_last_ptr) ? '0 : ptr + c_ptr_one;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({push, pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only entries below count are ever observed.
  always_ff @(posedge clock) begin
    if (push && !clear) r_mem[r_wr_ptr] <= push_data;
  end

  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign empty     = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mul_issue_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mul_issue_sched                                               |
// | Purpose  : Issue scheduler for the STAGES-deep pipelined multiplier.     |
// |            Starts the multiplier, carries each op's tag beside the pipe, |
// |            applies sign fix-up, queues results for the CDB and limits    |
// |            in-flight + queued ops so no result is ever dropped.          |
// | Ports    : clock, reset_n (async, active low)                            |
// |            issue_* : RS request / ready handshake and op tag             |
// |            flush   : squash every in-flight and queued op                |
// |            mult_*  : start pulse out, done + magnitude product in        |
// |            cdb_*   : result request / grant and head result fields       |
// |            busy    : any op in flight or queued                          |
// | Notes    : XLEN must equal MUL_XLEN (tag and result structs use it).     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mul_issue_sched
  import mul_issue_sched_pkg::*;
#(
  parameter int XLEN         = MUL_XLEN,
  parameter int STAGES       = MUL_STAGES,
  parameter int RESULT_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [1:0]          issue_func,
  input  logic                issue_a_sign,
  input  logic                issue_b_sign,
  input  logic [PRF_LEN-1:0]  issue_prf_idx,
  input  logic [ROB_LEN-1:0]  issue_rob_idx,
  input  logic [XLEN-1:0]     issue_pc,
  input  logic                flush,
  output logic                mult_start,
  input  logic                mult_done,
  input  logic [2*XLEN-1:0]   mult_product,
  output logic                cdb_req,
  input  logic                cdb_grant,
  output logic [XLEN-1:0]     cdb_value,
  output logic [PRF_LEN-1:0]  cdb_prf_idx,
  output logic [ROB_LEN-1:0]  cdb_rob_idx,
  output logic [XLEN-1:0]     cdb_pc,
  output logic                busy
);

  localparam int CNT_W = $clog2(RESULT_DEPTH + 1);
  localparam int RES_W = $bits(MUL_RESULT);
  localparam logic [CNT_W-1:0] c_depth   = CNT_W'(RESULT_DEPTH);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic [STAGES-1:0] r_pipe_valid;
  MUL_TAG            r_pipe_tag [STAGES];
  logic [CNT_W-1:0]  r_inflight_cnt;

  logic [STAGES-1:0] w_valid_shift;
  logic [CNT_W-1:0]  w_queue_cnt;
  logic [CNT_W-1:0]  w_occupancy;
  logic              w_queue_empty;
  logic              w_fire;
  logic              w_complete;
  logic              w_pop;
  MUL_TAG            w_issue_tag;
  MUL_TAG            w_done_tag;
  MUL_RESULT         w_push_result;
  MUL_RESULT         w_head_result;
  logic [RES_W-1:0]  w_head_bits;

  // ---------------------------------------------------------------- handshake
  // Counting in-flight ops against the queue depth reserves a slot for every
  // started op, so a completion always finds room.
  assign w_occupancy = r_inflight_cnt + w_queue_cnt;
  assign issue_ready = (w_occupancy < c_depth);
  assign w_fire      = issue_valid & issue_ready & ~flush;
  assign mult_start  = w_fire;
  assign busy        = (w_occupancy != '0);

  always_comb begin
    w_issue_tag         = '0;
    w_issue_tag.prf_idx = issue_prf_idx;
    w_issue_tag.rob_idx = issue_rob_idx;
    w_issue_tag.pc      = issue_pc;
    w_issue_tag.func    = MUL_FUNC'(issue_func);
    w_issue_tag.a_sign  = issue_a_sign;
    w_issue_tag.b_sign  = issue_b_sign;
  end

  // ----------------------------------------------------------------- tag pipe
  always_comb begin
    w_valid_shift    = '0;
    w_valid_shift[0] = w_fire;
    for (int i = 1; i < STAGES; i++) begin
      w_valid_shift[i] = r_pipe_valid[i-1];
    end
  end

  // Tags advance every cycle in lockstep with the multiplier; flush only
  // clears the valids, so a killed op's later done meets an invalid tag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pipe_valid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_pipe_tag[i] <= '0;
      end
    end else begin
      r_pipe_valid  <= flush ? '0 : w_valid_shift;
      r_pipe_tag[0] <= w_issue_tag;
      for (int i = 1; i < STAGES; i++) begin
        r_pipe_tag[i] <= r_pipe_tag[i-1];
      end
    end
  end

  // --------------------------------------------------------------- completion
  assign w_done_tag = r_pipe_tag[STAGES-1];
  assign w_complete = r_pipe_valid[STAGES-1] & mult_done & ~flush;

  always_comb begin
    w_push_result         = '0;
    w_push_result.value   = mul_sign_fix(w_done_tag.func, w_done_tag.a_sign,
                                         w_done_tag.b_sign, mult_product);
    w_push_result.prf_idx = w_done_tag.prf_idx;
    w_push_result.rob_idx = w_done_tag.rob_idx;
    w_push_result.pc      = w_done_tag.pc;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight_cnt <= '0;
    end else if (flush) begin
      r_inflight_cnt <= '0;
    end else begin
      case ({w_fire, w_complete})
        2'b10:   r_inflight_cnt <= r_inflight_cnt + c_cnt_one;
        2'b01:   r_inflight_cnt <= r_inflight_cnt - c_cnt_one;
        default: r_inflight_cnt <= r_inflight_cnt;
      endcase
    end
  end

  a_tag_has_done: assert property (@(posedge clock) disable iff (!reset_n)
                                   r_pipe_valid[STAGES-1] |-> mult_done);

  // ------------------------------------------------------------- result queue
  assign w_pop = ~w_queue_empty & cdb_grant & ~flush;

  mul_result_fifo #(
    .DEPTH (RESULT_DEPTH),
    .WIDTH (RES_W)
  ) u_result_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (flush),
    .push      (w_complete),
    .push_data (w_push_result),
    .pop       (w_pop),
    .head_data (w_head_bits),
    .count     (w_queue_cnt),
    .empty     (w_queue_empty)
  );

  // Data outputs read as zero whenever nothing is being offered.
  assign w_head_result = MUL_RESULT'(w_head_bits);
  assign cdb_req       = ~w_queue_empty;
  assign cdb_value     = cdb_req ? w_head_result.value   : '0;
  assign cdb_prf_idx   = cdb_req ? w_head_result.prf_idx : '0;
  assign cdb_rob_idx   = cdb_req ? w_head_result.rob_idx : '0;
  assign cdb_pc        = cdb_req ? w_head_result.pc      : '0;

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mul_issue_sched                                            |
// | Purpose  : Self-checking bench for mul_issue_sched: directed cases plus  |
// |            randomized traffic compared every cycle to a queue model.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mul_issue_sched;
  import mul_issue_sched_pkg::*;

  localparam int XLEN   = 32;
  localparam int STAGES = 8;
  localparam int DEPTH  = 4;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               issue_valid = 1'b0;
  logic               issue_ready;
  logic [1:0]         issue_func = 2'd0;
  logic               issue_a_sign = 1'b0;
  logic               issue_b_sign = 1'b0;
  logic [PRF_LEN-1:0] issue_prf_idx = '0;
  logic [ROB_LEN-1:0] issue_rob_idx = '0;
  logic [XLEN-1:0]    issue_pc = '0;
  logic               flush = 1'b0;
  logic               mult_start;
  logic               mult_done;
  logic [2*XLEN-1:0]  mult_product;
  logic               cdb_req;
  logic               cdb_grant = 1'b0;
  logic [XLEN-1:0]    cdb_value;
  logic [PRF_LEN-1:0] cdb_prf_idx;
  logic [ROB_LEN-1:0] cdb_rob_idx;
  logic [XLEN-1:0]    cdb_pc;
  logic               busy;

  // Full operand values travelling on the RS path to the multiplier.
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ncyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mul_issue_sched #(.XLEN(XLEN), .STAGES(STAGES), .RESULT_DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_func(issue_func),
    .issue_a_sign(issue_a_sign), .issue_b_sign(issue_b_sign),
    .issue_prf_idx(issue_prf_idx), .issue_rob_idx(issue_rob_idx), .issue_pc(issue_pc),
    .flush(flush), .mult_start(mult_start), .mult_done(mult_done), .mult_product(mult_product),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_value(cdb_value),
    .cdb_prf_idx(cdb_prf_idx), .cdb_rob_idx(cdb_rob_idx), .cdb_pc(cdb_pc), .busy(busy)
  );

  // ---------------------------------------------------- multiplier stand-in
  // Produces |a|*|b| exactly STAGES cycles after mult_start; it is never
  // flushed or reset, so killed ops still produce stray done pulses.
  logic        mq_done [STAGES];
  logic [63:0] mq_prod [STAGES];
  initial for (int i = 0; i < STAGES; i++) begin mq_done[i] = 1'b0; mq_prod[i] = '0; end

  function automatic logic [31:0] mag(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? -x : x;
  endfunction

  function automatic logic [63:0] mag_product(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ma, mb;
    ma = {32'b0, mag(a, f != 2'd3)};
    mb = {32'b0, mag(b, f == 2'd0 || f == 2'd1)};
    return ma * mb;
  endfunction

  always @(posedge clock) begin
    mq_done[0] <= mult_start;
    mq_prod[0] <= mag_product(issue_func, op_a, op_b);
    for (int i = 1; i < STAGES; i++) begin
      mq_done[i] <= mq_done[i-1];
      mq_prod[i] <= mq_prod[i-1];
    end
  end
  assign mult_done    = mq_done[STAGES-1];
  assign mult_product = mq_prod[STAGES-1];

  // --------------------------------------------------------------- reference
  // Architectural result: extend operands to 64 bits by the op's signedness,
  // multiply modulo 2^64, keep the requested half.
  function automatic logic [31:0] ref_result(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (f == 2'd3) ? {32'b0, a} : {{32{a[31]}}, a};
    eb = (f == 2'd0 || f == 2'd1) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (f == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  typedef struct {
    logic [31:0]        value;
    logic [PRF_LEN-1:0] prf;
    logic [ROB_LEN-1:0] rob;
    logic [31:0]        pc;
    int                 due;
  } op_t;

  op_t m_fly[$];
  op_t m_rq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare then advance the model once per cycle, mid-cycle.
  always @(negedge clock) begin : p_compare
    int   occ;
    logic exp_ready, exp_start, exp_req;
    op_t  o;
    if (!reset_n) begin
      m_fly.delete();
      m_rq.delete();
    end
    occ       = m_fly.size() + m_rq.size();
    exp_ready = (occ < DEPTH);
    exp_start = issue_valid && exp_ready && !flush;
    exp_req   = (m_rq.size() != 0);
    check("issue_ready", issue_ready, exp_ready);
    check("mult_start", mult_start, exp_start);
    check("cdb_req", cdb_req, exp_req);
    check("busy", busy, occ != 0);
    if (exp_req) begin
      check("cdb_value", cdb_value, m_rq[0].value);
      check("cdb_prf_idx", cdb_prf_idx, m_rq[0].prf);
      check("cdb_rob_idx", cdb_rob_idx, m_rq[0].rob);
      check("cdb_pc", cdb_pc, m_rq[0].pc);
    end
    if (reset_n) begin
      if (flush) begin
        m_fly.delete();
        m_rq.delete();
      end else begin
        if (exp_req && cdb_grant) void'(m_rq.pop_front());
        if (m_fly.size() != 0 && m_fly[0].due == ncyc) m_rq.push_back(m_fly.pop_front());
        if (exp_start) begin
          o.value = ref_result(issue_func, op_a, op_b);
          o.prf   = issue_prf_idx;
          o.rob   = issue_rob_idx;
          o.pc    = issue_pc;
          o.due   = ncyc + STAGES;
          m_fly.push_back(o);
        end
      end
    end
    ncyc++;
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [PRF_LEN-1:0] prf, input logic [ROB_LEN-1:0] rob, input logic [31:0] pc);
    issue_valid   = 1'b1;
    issue_func    = f;
    op_a          = a;
    op_b          = b;
    issue_a_sign  = a[31];
    issue_b_sign  = b[31];
    issue_prf_idx = prf;
    issue_rob_idx = rob;
    issue_pc      = pc;
  endtask

  // Issue one op into an empty scheduler, hold grant off until it appears,
  // check latency and literal result, then let the CDB take it.
  task automatic run_directed(input string name, input logic [1:0] f, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp_val,
                              input logic [PRF_LEN-1:0] prf, input logic [ROB_LEN-1:0] rob,
                              input logic [31:0] pc);
    int p, w;
    tick();
    cdb_grant = 1'b0;
    set_op(f, a, b, prf, rob, pc);
    #1;
    check({name, "_start"}, mult_start, 1'b1);
    p = cyc;
    tick();
    issue_valid = 1'b0;
    #1;
    w = 0;
    while (!cdb_req && w < 40) begin tick(); #1; w++; end
    check({name, "_latency"}, cyc - p, STAGES + 1);
    check({name, "_value"}, cdb_value, exp_val);
    check({name, "_model_value"}, (m_rq.size() != 0) ? m_rq[0].value : 32'hDEAD_BEEF, exp_val);
    check({name, "_prf"}, cdb_prf_idx, prf);
    check({name, "_rob"}, cdb_rob_idx, rob);
    check({name, "_pc"}, cdb_pc, pc);
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
  endtask

  task automatic drain();
    int w;
    issue_valid = 1'b0;
    flush       = 1'b0;
    cdb_grant   = 1'b1;
    w = 0;
    #1;
    while (busy && w < 60) begin tick(); #1; w++; end
    cdb_grant = 1'b0;
    check("drain_busy", busy, 1'b0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] tbl [4];
    tbl[0] = 32'h0000_0000;
    tbl[1] = 32'hFFFF_FFFF;
    tbl[2] = 32'h8000_0000;
    tbl[3] = 32'h7FFF_FFFF;
    return ($urandom_range(0, 3) == 0) ? tbl[$urandom_range(0, 3)] : $urandom;
  endfunction

  initial begin : p_main
    int acc, stray, w;
    // Reset state
    tick();
    tick();
    #1;
    check("rst_issue_ready", issue_ready, 1'b1);
    check("rst_cdb_req", cdb_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_mult_start", mult_start, 1'b0);
    check("rst_cdb_value", cdb_value, 32'h0);
    tick();
    reset_n = 1'b1;

    // Directed sign fix-up cases
    run_directed("mul_3x_m5", 2'd0, 32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFF1, 6'd1, 5'd2, 32'h0000_0100);
    run_directed("mulhu_max", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 6'd2, 5'd3, 32'h0000_0104);
    run_directed("mulh_m1_m1", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 6'd3, 5'd4, 32'h0000_0108);
    run_directed("mulhsu_m1_1", 2'd2, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 6'd4, 5'd5, 32'h0000_010C);

    // Backpressure: six back-to-back requests with no grant
    tick();
    set_op(2'd0, 32'd11, 32'd13, 6'd10, 5'd10, 32'h200);
    acc = 0;
    for (int i = 0; i < 6; i++) begin #1; if (mult_start) acc++; tick(); end
    issue_valid = 1'b0;
    check("bp_accepted", acc, 4);
    #1;
    check("bp_ready_low", issue_ready, 1'b0);
    repeat (12) tick();
    #1;
    check("bp_queue_req", cdb_req, 1'b1);
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
    set_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 6'd11, 5'd11, 32'h204);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i == 0) check("bp_ready_after_grant", issue_ready, 1'b1);
      if (mult_start) acc++;
      tick();
    end
    issue_valid = 1'b0;
    check("bp_one_more", acc, 1);
    drain();

    // Flush with one op queued and two in flight
    tick();
    set_op(2'd0, 32'd2, 32'd3, 6'd20, 5'd20, 32'h300);
    tick();
    issue_valid = 1'b0;
    #1;
    w = 0;
    while (!cdb_req && w < 40) begin tick(); #1; w++; end
    check("fl_setup_req", cdb_req, 1'b1);
    tick();
    set_op(2'd1, 32'hFFFF_0000, 32'd7, 6'd21, 5'd21, 32'h304);
    tick();
    set_op(2'd3, 32'h0000_FFFF, 32'd9, 6'd22, 5'd22, 32'h308);
    tick();
    issue_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("fl_cdb_req", cdb_req, 1'b0);
    check("fl_busy", busy, 1'b0);
    stray = 0;
    repeat (12) begin tick(); #1; if (cdb_req) stray++; end
    check("fl_stray_done", stray, 0);
    run_directed("post_flush", 2'd0, 32'd7, 32'd6, 32'd42, 6'd5, 5'd9, 32'h0000_1000);

    // Asynchronous reset with occupancy at the cap (3 queued, 1 in flight)
    tick();
    set_op(2'd0, 32'd5, 32'd5, 6'd30, 5'd30, 32'h400);
    repeat (3) tick();
    issue_valid = 1'b0;
    repeat (10) tick();
    set_op(2'd2, 32'h8000_0000, 32'd3, 6'd31, 5'd31, 32'h404);
    tick();
    issue_valid = 1'b0;
    tick();
    #1;
    check("ar_pre_ready", issue_ready, 1'b0);
    check("ar_pre_req", cdb_req, 1'b1);
    reset_n = 1'b0;
    #1;
    check("ar_cdb_req", cdb_req, 1'b0);
    check("ar_busy", busy, 1'b0);
    check("ar_issue_ready", issue_ready, 1'b1);
    check("ar_cdb_value", cdb_value, 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    stray = 0;
    repeat (14) begin tick(); #1; if (cdb_req) stray++; end
    check("ar_stray_done", stray, 0);
    check("ar_ready_after", issue_ready, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      set_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
             PRF_LEN'($urandom), ROB_LEN'($urandom), $urandom);
      issue_valid = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 99) < 3);
      cdb_grant   = ($urandom_range(0, 1) == 1);
    end
    tick();
    drain();
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin : p_watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
